hub75_column_fetcher: RTL
=========================

// Module: hub75_column_fetcher
// PURPOSE
//  Upstream feeder of the HUB75 panel driver. For the current rotation slice (theta) it
//  reads one scan line pair from the slice-frame BRAM. Upper row = addr, lower row =
//  addr + SCAN_RATE. It packs both into column_data and offers it with a valid/ready
//  handshake. It walks scan addresses 0..SCAN_RATE-1 repeatedly and swaps theta only at
//  frame boundaries.
// PARAMETERS
//  NUM_COLS      64  pixels shifted per row (per half)
//  NUM_ROWS      64  panel rows; two halves of SCAN_RATE rows each
//  SCAN_RATE     32  scan addresses per frame; NUM_ROWS == 2*SCAN_RATE
//  THETA_RES     8   theta index width (2**THETA_RES slices)
//  RGB_RES       9   pixel word width (3 bits each R,G,B; bit planes packed as downstream expects)
//  BRAM_LATENCY  2   BRAM read latency in cycles (1..4)
// PORTS
//  clk_in          in   1                              system clock
//  rst_in_n        in   1                              async active-low reset
//  theta_in        in   THETA_RES                      new slice index
//  theta_valid_in  in   1                              1-cycle strobe qualifying theta_in
//  bram_addr_out   out  THETA_RES+clog2(NUM_ROWS)+clog2(NUM_COLS)  {theta,row,col}
//  bram_en_out     out  1                              read enable
//  bram_data_in    in   RGB_RES                        read data, BRAM_LATENCY after en
//  column_data     out  [1:0][NUM_ROWS-1:0][RGB_RES-1:0] [half][pixel] staged line pair
//  address_data    out  clog2(SCAN_RATE)               scan address of column_data
//  tvalid          out  1                              staged data valid
//  tready          in   1                              driver idle/accepting
//  frame_done_out  out  1                              1-cycle pulse: address wrapped
//  slice_drop_out  out  1                              1-cycle pulse: pending theta overwritten
// BEHAVIOUR
//  Clocking: one clock, clk_in. Reset: rst_in_n, asynchronous and active-low.
//  Reset values: all outputs 0; state IDLE; pending flag 0; scan address 0.
//  State machine:
//   IDLE -> FETCH on the first theta_valid_in; theta_in loads into the active theta.
//   FETCH: issues 2*NUM_COLS reads, one per cycle, bram_en_out=1, in this order:
//     half 0, col 0..NUM_COLS-1, row=addr; then half 1, col 0..NUM_COLS-1, row=addr+SCAN_RATE.
//     A BRAM_LATENCY-deep valid delay line tags returns.
//     Return k is written to column_data[k/NUM_COLS][k%NUM_COLS].
//     bram_en_out=0 after the last issue. Go to PRESENT when the last return is captured.
//   PRESENT: tvalid=1.
//     column_data and address_data are held stable until tvalid&&tready at a rising edge.
//     On accept: tvalid=0 next cycle, addr<=addr+1 mod SCAN_RATE, go to FETCH.
//  Latency: FETCH entry at cycle F gives tvalid high at F+2*NUM_COLS+BRAM_LATENCY.
//  Theta update:
//   A theta_valid_in outside IDLE stores theta_in as pending and sets the pending flag.
//   If pending is already set, the new value overwrites it and slice_drop_out pulses.
//   The active theta changes only on the accept where addr wraps SCAN_RATE-1 -> 0.
//   On that accept frame_done_out pulses; if pending is set, active <= pending and pending clears.
//   With no pending theta, the same slice refreshes indefinitely.
//  Simultaneous events:
//   theta_valid_in in the wrap-accept cycle: the incoming value is used directly as the
//   next active theta. An older pending value is dropped, with a slice_drop_out pulse.
//  Reset mid-operation (async):
//   Aborts everything: outputs cleared immediately, in-flight BRAM returns ignored.
//   After release the block waits in IDLE for a fresh theta_valid_in.
//  Widths: row = addr + half*SCAN_RATE fits clog2(NUM_ROWS) bits; column/read counters wrap exactly.
//  Whole-column writes: column_data is written one pixel at a time during FETCH and never changes during PRESENT.
// STRUCTURE
//  hub75_pkg holds:
//   - the fetcher state enum (IDLE, FETCH, PRESENT);
//   - localparams for BRAM address field widths;
//   - a function packing {theta,row,col}.
//  One sub-module, bram_valid_pipe: a parameterised BRAM_LATENCY-deep shift register of
//  {valid, half, col} tags. Everything else is flat in this module.
// TESTING
//  1 Reset, then theta_valid_in with theta=5; BRAM model data = addr[8:0]:
//    tvalid rises 128+2 cycles after FETCH entry, address_data=0,
//    column_data[1][3]=pack(5,32,3)[8:0].
//  2 tready held 0 for 50 cycles while tvalid=1:
//    column_data, address_data and tvalid stay stable; no BRAM reads issue.
//  3 Accept 32 lines with tready=1:
//    address_data runs 0..31 then 0; frame_done_out pulses once, on the 32nd accept.
//  4 Theta 9 then theta 10 sent mid-frame:
//    one slice_drop_out pulse; the next frame reads theta 10; theta 9 is never read.
//  5 theta_valid_in coincident with the wrap accept:
//    the next FETCH uses that theta immediately.
//  6 rst_in_n low mid-FETCH:
//    outputs 0 asynchronously; stale BRAM returns after release are ignored; stays IDLE until theta_valid_in.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 feed path.
// Holds the fetcher state encoding and the BRAM address packing.
package hub75_pkg;

  localparam int THETA_W = 8;
  localparam int ROW_W   = 6;
  localparam int COL_W   = 6;
  localparam int ADDR_W  = THETA_W + ROW_W + COL_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } fetch_state_e;

  function automatic logic [ADDR_W-1:0] pack_addr(
    input logic [THETA_W-1:0] theta,
    input logic [ROW_W-1:0]   row,
    input logic [COL_W-1:0]   col
  );
    return {theta, row, col};
  endfunction

endpackage

// File: rtl/hub75_column_fetcher_valid_pipe.sv
// Delay line that tags BRAM reads so returns land in the right pixel.
// Cleared on reset so in-flight returns are dropped.
module bram_valid_pipe #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk_in,
  input  logic         rst_in_n,
  input  logic [W-1:0] tag_in,
  output logic [W-1:0] tag_out
);

  logic [DEPTH-1:0][W-1:0] sr;

  // shift tags one stage per cycle
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      sr <= '0;
    end else begin
      sr[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign tag_out = sr[DEPTH-1];

endmodule

// File: rtl/hub75_column_fetcher.sv
// Reads one scan line pair per address from the slice BRAM and
// offers it to the panel driver; theta swaps only at frame wrap.
module hub75_column_fetcher
  import hub75_pkg::*;
#(
  parameter int NUM_COLS     = 64,
  parameter int NUM_ROWS     = 64,
  parameter int SCAN_RATE    = 32,
  parameter int THETA_RES    = 8,
  parameter int RGB_RES      = 9,
  parameter int BRAM_LATENCY = 2
) (
  input  logic clk_in,
  input  logic rst_in_n,
  input  logic [THETA_RES-1:0] theta_in,
  input  logic theta_valid_in,
  output logic [THETA_RES+$clog2(NUM_ROWS)
                +$clog2(NUM_COLS)-1:0] bram_addr_out,
  output logic bram_en_out,
  input  logic [RGB_RES-1:0] bram_data_in,
  output logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] column_data,
  output logic [$clog2(SCAN_RATE)-1:0] address_data,
  output logic tvalid,
  input  logic tready,
  output logic frame_done_out,
  output logic slice_drop_out
);

  localparam int RW = $clog2(NUM_ROWS);
  localparam int CW = $clog2(NUM_COLS);
  localparam int SW = $clog2(SCAN_RATE);
  localparam int KW = CW + 1;

  fetch_state_e state_q, state_d;

  logic [THETA_RES-1:0] theta_act;
  logic [THETA_RES-1:0] theta_pend;
  logic                 pend_q;
  logic [SW-1:0]        addr_q;
  logic [KW-1:0]        rd_cnt;
  logic                 issue_done;

  logic          iss_half;
  logic [CW-1:0] iss_col;
  logic [RW-1:0] iss_row;
  logic          ret_vld;
  logic          ret_half;
  logic [CW-1:0] ret_col;
  logic          last_ret;
  logic          accept;
  logic          wrap;

  assign iss_half = rd_cnt[KW-1];
  assign iss_col  = rd_cnt[CW-1:0];
  assign iss_row  = RW'(addr_q)
                  + (iss_half ? RW'(SCAN_RATE) : '0);

  assign bram_en_out   = (state_q == FETCH) && !issue_done;
  assign bram_addr_out = {theta_act, iss_row, iss_col};

  assign tvalid       = (state_q == PRESENT);
  assign address_data = addr_q;
  assign accept       = tvalid && tready;
  assign wrap         = accept
                      && (addr_q == SW'(SCAN_RATE - 1));

  assign last_ret = ret_vld && ret_half
                  && (ret_col == CW'(NUM_COLS - 1));

  bram_valid_pipe #(
    .DEPTH (BRAM_LATENCY),
    .W     (CW + 2)
  ) u_valid_pipe (
    .clk_in   (clk_in),
    .rst_in_n (rst_in_n),
    .tag_in   ({bram_en_out, iss_half, iss_col}),
    .tag_out  ({ret_vld, ret_half, ret_col})
  );

  // state register
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (theta_valid_in) state_d = FETCH;
      FETCH:   if (last_ret)       state_d = PRESENT;
      PRESENT: if (accept)         state_d = FETCH;
      default:                     state_d = IDLE;
    endcase
  end

  // read issue counter, one read per cycle in FETCH
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      rd_cnt     <= '0;
      issue_done <= 1'b0;
    end else if (state_q != FETCH) begin
      rd_cnt     <= '0;
      issue_done <= 1'b0;
    end else if (!issue_done) begin
      rd_cnt <= rd_cnt + 1'b1;
      if (&rd_cnt) issue_done <= 1'b1;
    end
  end

  // capture tagged returns into the staged line pair
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      column_data <= '0;
    end else if (state_q == FETCH && ret_vld) begin
      column_data[ret_half][ret_col] <= bram_data_in;
    end
  end

  // scan address advances on each accepted line
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n)   addr_q <= '0;
    else if (wrap)   addr_q <= '0;
    else if (accept) addr_q <= addr_q + 1'b1;
  end

  // active/pending theta and the frame/drop pulses
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      theta_act      <= '0;
      theta_pend     <= '0;
      pend_q         <= 1'b0;
      frame_done_out <= 1'b0;
      slice_drop_out <= 1'b0;
    end else begin
      frame_done_out <= 1'b0;
      slice_drop_out <= 1'b0;
      if (state_q == IDLE) begin
        if (theta_valid_in) theta_act <= theta_in;
      end else if (wrap) begin
        frame_done_out <= 1'b1;
        if (theta_valid_in) begin
          theta_act      <= theta_in;
          slice_drop_out <= pend_q;
          pend_q         <= 1'b0;
        end else if (pend_q) begin
          theta_act <= theta_pend;
          pend_q    <= 1'b0;
        end
      end else if (theta_valid_in) begin
        theta_pend     <= theta_in;
        pend_q         <= 1'b1;
        slice_drop_out <= pend_q;
      end
    end
  end

endmodule
